// File: rtl/rob_superscalar_pkg.sv
// Shared ROB types: tag type, entry record and a small lane-count helper.
// No logic; pure declarations.
// No flow control of its own.
package rob_superscalar_pkg;

    localparam int ROB_DEPTH  = 16;
    localparam int ROB_TAG_W  = $clog2(ROB_DEPTH);
    localparam int ROB_ARCH_W = 5;
    localparam int ROB_XLEN   = 32;

    typedef logic [ROB_TAG_W-1:0] ROB_TAG_T;

    typedef struct packed {
        logic                  valid;
        logic                  complete;
        logic                  mispred;
        logic                  has_dest;
        logic [ROB_ARCH_W-1:0] dest;
        logic [ROB_XLEN-1:0]   value;
    } ROB_SS_ENTRY;

    // Lane vectors are at most 4 wide and contiguous from lane 0.
    function automatic logic [2:0] lane_count(input logic [3:0] v);
        lane_count = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/rob_ss_retire_sel.sv
// Retire lane selector: prefix-AND of head-window done bits, stopping after a mispredict.
// Purely combinational, zero latency.
// No backpressure; lanes beyond the first incomplete entry are simply not offered.
module rob_ss_retire_sel #(
    parameter int RT_W = 2
) (
    input  logic [RT_W-1:0] win_done,
    input  logic [RT_W-1:0] win_mp,
    output logic [RT_W-1:0] rt_valid,
    output logic            flush
);

    logic run;

    always_comb begin
        rt_valid = '0;
        flush    = 1'b0;
        run      = 1'b1;
        for (int i = 0; i < RT_W; i++) begin
            rt_valid[i] = run & win_done[i];
            if (rt_valid[i] && win_mp[i]) begin
                flush = 1'b1;
            end
            run = run & win_done[i] & ~win_mp[i];
        end
    end

endmodule

// File: rtl/rob_superscalar.sv
// N-wide reorder buffer: in-order allocate, out-of-order complete via CDB, in-order retire/flush.
// Dispatch tags and retire lanes are combinational from registered state; updates land at the edge.
// Dispatch is all-or-nothing against dp_free; ROB_CDB_BYPASS_EN adds same-cycle CDB forwarding to lookups.
module rob_superscalar
    import rob_superscalar_pkg::*;
#(
    parameter int  DEPTH  = ROB_DEPTH,
    parameter int  DP_W   = 2,
    parameter int  RT_W   = 2,
    parameter int  CDB_W  = 2,
    parameter int  RD_P   = 4,
    localparam int TAG_W  = $clog2(DEPTH),
    localparam int ARCH_W = ROB_ARCH_W,
    localparam int XLEN   = ROB_XLEN
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DP_W-1:0]         dp_valid,
    input  logic [DP_W-1:0]         dp_has_dest,
    input  logic [DP_W*ARCH_W-1:0]  dp_dest,
    output logic [TAG_W:0]          dp_free,
    output logic [DP_W*TAG_W-1:0]   dp_tag,
    input  logic [CDB_W-1:0]        cdb_valid,
    input  logic [CDB_W*TAG_W-1:0]  cdb_tag,
    input  logic [CDB_W*XLEN-1:0]   cdb_value,
    input  logic [CDB_W-1:0]        cdb_mispred,
    input  logic [RD_P*TAG_W-1:0]   rd_tag,
    output logic [RD_P-1:0]         rd_ready,
    output logic [RD_P*XLEN-1:0]    rd_value,
    output logic [RT_W-1:0]         rt_valid,
    output logic [RT_W*TAG_W-1:0]   rt_tag,
    output logic [RT_W-1:0]         rt_has_dest,
    output logic [RT_W*ARCH_W-1:0]  rt_dest,
    output logic [RT_W*XLEN-1:0]    rt_value,
    output logic                    flush,
    output logic                    empty,
    output logic                    full
);

    localparam logic [TAG_W:0] DEPTH_V = (TAG_W+1)'(DEPTH);

    ROB_SS_ENTRY [DEPTH-1:0] ent_q, ent_d;
    logic [TAG_W:0]          head_q, head_d, tail_q, tail_d, count;
    logic [TAG_W-1:0]        rt_idx [RT_W];
    logic [RT_W-1:0]         win_done, win_mp;
    logic [2:0]              dp_n, rt_n;
    logic                    dp_accept;
    logic                    cdb_dup;

    // The wrap bit makes count==DEPTH (full) distinct from count==0 (empty).
    always_comb begin
        count     = tail_q - head_q;
        dp_free   = DEPTH_V - count;
        empty     = (count == '0);
        full      = (count == DEPTH_V);
        dp_n      = lane_count(4'(dp_valid));
        rt_n      = lane_count(4'(rt_valid));
        dp_accept = (dp_n != 3'd0) && ((TAG_W+1)'(dp_n) <= dp_free) && !flush;
    end

    always_comb begin
        dp_tag = '0;
        for (int i = 0; i < DP_W; i++) begin
            if (dp_valid[i]) begin
                dp_tag[i*TAG_W +: TAG_W] = tail_q[TAG_W-1:0] + TAG_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RT_W; i++) begin
            rt_idx[i] = head_q[TAG_W-1:0] + TAG_W'(i);
        end
    end

    always_comb begin
        win_done = '0;
        win_mp   = '0;
        for (int i = 0; i < RT_W; i++) begin
            win_done[i] = ent_q[rt_idx[i]].valid & ent_q[rt_idx[i]].complete;
            win_mp[i]   = ent_q[rt_idx[i]].mispred;
        end
    end

    rob_ss_retire_sel #(
        .RT_W (RT_W)
    ) u_retire_sel (
        .win_done (win_done),
        .win_mp   (win_mp),
        .rt_valid (rt_valid),
        .flush    (flush)
    );

    always_comb begin
        rt_tag      = '0;
        rt_has_dest = '0;
        rt_dest     = '0;
        rt_value    = '0;
        for (int i = 0; i < RT_W; i++) begin
            if (rt_valid[i]) begin
                rt_tag[i*TAG_W +: TAG_W]    = rt_idx[i];
                rt_has_dest[i]              = ent_q[rt_idx[i]].has_dest;
                rt_dest[i*ARCH_W +: ARCH_W] = ent_q[rt_idx[i]].dest;
                rt_value[i*XLEN +: XLEN]    = ent_q[rt_idx[i]].value;
            end
        end
    end

    always_comb begin
        rd_ready = '0;
        rd_value = '0;
        for (int p = 0; p < RD_P; p++) begin
            if (ent_q[rd_tag[p*TAG_W +: TAG_W]].valid && ent_q[rd_tag[p*TAG_W +: TAG_W]].complete) begin
                rd_ready[p]              = 1'b1;
                rd_value[p*XLEN +: XLEN] = ent_q[rd_tag[p*TAG_W +: TAG_W]].value;
            end
`ifdef ROB_CDB_BYPASS_EN
            // Scan high to low so the lowest matching port is the one left standing.
            for (int c = CDB_W - 1; c >= 0; c--) begin
                if (cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == rd_tag[p*TAG_W +: TAG_W])
                    && ent_q[rd_tag[p*TAG_W +: TAG_W]].valid) begin
                    rd_ready[p]              = 1'b1;
                    rd_value[p*XLEN +: XLEN] = cdb_value[c*XLEN +: XLEN];
                end
            end
`endif
        end
    end

    always_comb begin
        ent_d  = ent_q;
        head_d = head_q + (TAG_W+1)'(rt_n);
        tail_d = tail_q;
        for (int c = 0; c < CDB_W; c++) begin
            if (cdb_valid[c] && ent_q[cdb_tag[c*TAG_W +: TAG_W]].valid) begin
                ent_d[cdb_tag[c*TAG_W +: TAG_W]].complete = 1'b1;
                ent_d[cdb_tag[c*TAG_W +: TAG_W]].mispred  = cdb_mispred[c];
                ent_d[cdb_tag[c*TAG_W +: TAG_W]].value    = cdb_value[c*XLEN +: XLEN];
            end
        end
        for (int i = 0; i < RT_W; i++) begin
            if (rt_valid[i]) begin
                ent_d[rt_idx[i]] = '0;
            end
        end
        // Slots freed by this cycle's retire were not counted in dp_free, so no overlap here.
        if (dp_accept) begin
            for (int i = 0; i < DP_W; i++) begin
                if (dp_valid[i]) begin
                    ent_d[tail_q[TAG_W-1:0] + TAG_W'(i)]          = '0;
                    ent_d[tail_q[TAG_W-1:0] + TAG_W'(i)].valid    = 1'b1;
                    ent_d[tail_q[TAG_W-1:0] + TAG_W'(i)].has_dest = dp_has_dest[i];
                    ent_d[tail_q[TAG_W-1:0] + TAG_W'(i)].dest     = dp_dest[i*ARCH_W +: ARCH_W];
                end
            end
            tail_d = tail_q + (TAG_W+1)'(dp_n);
        end
        if (flush) begin
            ent_d  = '0;
            head_d = '0;
            tail_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ent_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            ent_q  <= ent_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_comb begin
        cdb_dup = 1'b0;
        for (int i = 0; i < CDB_W; i++) begin
            for (int j = i + 1; j < CDB_W; j++) begin
                if (cdb_valid[i] && cdb_valid[j]
                    && (cdb_tag[i*TAG_W +: TAG_W] == cdb_tag[j*TAG_W +: TAG_W])) begin
                    cdb_dup = 1'b1;
                end
            end
        end
    end

    a_cdb_unique_tag: assert property (@(posedge clock) disable iff (!reset) !cdb_dup);

endmodule

// File: tb/tb_rob_superscalar.sv
// Directed bench for rob_superscalar: per-cycle vector table plus reset and lookup sequences.
// Vectors are driven just after the falling edge and checked 1 time unit later.
module tb_rob_superscalar;
    import rob_superscalar_pkg::*;

    localparam int DP_W   = 2;
    localparam int RT_W   = 2;
    localparam int CDB_W  = 2;
    localparam int RD_P   = 4;
    localparam int TAG_W  = ROB_TAG_W;
    localparam int ARCH_W = ROB_ARCH_W;
    localparam int XLEN   = ROB_XLEN;

    logic                   clock;
    logic                   reset;
    logic [DP_W-1:0]        dp_valid;
    logic [DP_W-1:0]        dp_has_dest;
    logic [DP_W*ARCH_W-1:0] dp_dest;
    logic [TAG_W:0]         dp_free;
    logic [DP_W*TAG_W-1:0]  dp_tag;
    logic [CDB_W-1:0]       cdb_valid;
    logic [CDB_W*TAG_W-1:0] cdb_tag;
    logic [CDB_W*XLEN-1:0]  cdb_value;
    logic [CDB_W-1:0]       cdb_mispred;
    logic [RD_P*TAG_W-1:0]  rd_tag;
    logic [RD_P-1:0]        rd_ready;
    logic [RD_P*XLEN-1:0]   rd_value;
    logic [RT_W-1:0]        rt_valid;
    logic [RT_W*TAG_W-1:0]  rt_tag;
    logic [RT_W-1:0]        rt_has_dest;
    logic [RT_W*ARCH_W-1:0] rt_dest;
    logic [RT_W*XLEN-1:0]   rt_value;
    logic                   flush;
    logic                   empty;
    logic                   full;

    int n_tests = 0;
    int n_fail  = 0;

    rob_superscalar #(
        .DEPTH (16),
        .DP_W  (DP_W),
        .RT_W  (RT_W),
        .CDB_W (CDB_W),
        .RD_P  (RD_P)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .dp_valid    (dp_valid),
        .dp_has_dest (dp_has_dest),
        .dp_dest     (dp_dest),
        .dp_free     (dp_free),
        .dp_tag      (dp_tag),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_value   (cdb_value),
        .cdb_mispred (cdb_mispred),
        .rd_tag      (rd_tag),
        .rd_ready    (rd_ready),
        .rd_value    (rd_value),
        .rt_valid    (rt_valid),
        .rt_tag      (rt_tag),
        .rt_has_dest (rt_has_dest),
        .rt_dest     (rt_dest),
        .rt_value    (rt_value),
        .flush       (flush),
        .empty       (empty),
        .full        (full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One record per cycle: inputs, then the outputs expected during that same cycle.
    typedef struct {
        logic [1:0] dpv;
        logic [1:0] cv;
        logic [3:0] ct0;
        logic [3:0] ct1;
        logic [1:0] cmp;
        logic [4:0] x_free;
        logic [7:0] x_dpt;
        logic [1:0] x_rtv;
        logic [7:0] x_rtt;
        logic       x_flush;
        logic       x_empty;
        logic       x_full;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] dpv, input logic [1:0] cv,
                                input logic [3:0] ct0, input logic [3:0] ct1,
                                input logic [1:0] cmp, input logic [4:0] fr,
                                input logic [7:0] dpt, input logic [1:0] rtv,
                                input logic [7:0] rtt, input logic fl,
                                input logic em, input logic fu);
        vec_t v;
        v.dpv = dpv; v.cv = cv; v.ct0 = ct0; v.ct1 = ct1; v.cmp = cmp;
        v.x_free = fr; v.x_dpt = dpt; v.x_rtv = rtv; v.x_rtt = rtt;
        v.x_flush = fl; v.x_empty = em; v.x_full = fu;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        dp_valid    = '0;
        dp_has_dest = '0;
        dp_dest     = '0;
        cdb_valid   = '0;
        cdb_tag     = '0;
        cdb_value   = '0;
        cdb_mispred = '0;
        rd_tag      = '0;
    endtask

    // Each entry's dest is its tag+7 and each CDB value is 0xC0DE0000|tag, so retire data is predictable.
    task automatic drive(input vec_t v);
        idle();
        dp_valid    = v.dpv;
        dp_has_dest = v.dpv;
        dp_dest     = {5'(v.x_dpt[7:4]) + 5'd7, 5'(v.x_dpt[3:0]) + 5'd7};
        cdb_valid   = v.cv;
        cdb_tag     = {v.ct1, v.ct0};
        cdb_value   = {32'hC0DE0000 | 32'(v.ct1), 32'hC0DE0000 | 32'(v.ct0)};
        cdb_mispred = v.cmp;
    endtask

    task automatic check_vec(input vec_t v, input string id);
        logic [63:0] ev;
        logic [9:0]  ed;
        ev = '0;
        ed = '0;
        for (int i = 0; i < RT_W; i++) begin
            if (v.x_rtv[i]) begin
                ev[i*32 +: 32] = 32'hC0DE0000 | 32'(v.x_rtt[i*4 +: 4]);
                ed[i*5 +: 5]   = 5'(v.x_rtt[i*4 +: 4]) + 5'd7;
            end
        end
        chk({id, " dp_free"},     64'(dp_free),     64'(v.x_free));
        chk({id, " dp_tag"},      64'(dp_tag),      64'(v.x_dpt));
        chk({id, " rt_valid"},    64'(rt_valid),    64'(v.x_rtv));
        chk({id, " rt_tag"},      64'(rt_tag),      64'(v.x_rtt));
        chk({id, " rt_has_dest"}, 64'(rt_has_dest), 64'(v.x_rtv));
        chk({id, " rt_dest"},     64'(rt_dest),     64'(ed));
        chk({id, " rt_value"},    64'(rt_value),    ev);
        chk({id, " flush"},       64'(flush),       64'(v.x_flush));
        chk({id, " empty"},       64'(empty),       64'(v.x_empty));
        chk({id, " full"},        64'(full),        64'(v.x_full));
    endtask

    task automatic run_table(input string pfx);
        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clock);
            drive(tbl[k]);
            #1;
            check_vec(tbl[k], $sformatf("%s%0d", pfx, k));
        end
    endtask

    logic exp_byp;

    initial begin
        idle();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("reset empty",    64'(empty),    64'd1);
        chk("reset full",     64'(full),     64'd0);
        chk("reset dp_free",  64'(dp_free),  64'd16);
        chk("reset rt_valid", 64'(rt_valid), 64'd0);
        chk("reset flush",    64'(flush),    64'd0);
        chk("reset dp_tag",   64'(dp_tag),   64'd0);
        chk("reset rd_ready", 64'(rd_ready), 64'd0);
        reset = 1'b1;

        // Fill to full, wrap, out-of-order completion, dp_free boundary cases.
        //             dpv    cv     ct0    ct1    cmp    free    dp_tag  rtv    rt_tag  fl    em    fu
        tbl.push_back(mk(2'b11, 2'b00, 4'd0, 4'd0, 2'b00, 5'd16, 8'h10, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(2'b11, 2'b00, 4'd0, 4'd0, 2'b00, 5'd14, 8'h32, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(2'b11, 2'b00, 4'd0, 4'd0, 2'b00, 5'd12, 8'h54, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(2'b11, 2'b00, 4'd0, 4'd0, 2'b00, 5'd10, 8'h76, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(2'b11, 2'b00, 4'd0, 4'd0, 2'b00, 5'd8,  8'h98, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(2'b11, 2'b00, 4'd0, 4'd0, 2'b00, 5'd6,  8'hBA, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(2'b11, 2'b00, 4'd0, 4'd0, 2'b00, 5'd4,  8'hDC, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(2'b11, 2'b00, 4'd0, 4'd0, 2'b00, 5'd2,  8'hFE, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(2'b11, 2'b00, 4'd0, 4'd0, 2'b00, 5'd0,  8'h10, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(2'b00, 2'b11, 4'd3, 4'd1, 2'b00, 5'd0,  8'h00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(2'b00, 2'b01, 4'd0, 4'd0, 2'b00, 5'd0,  8'h00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(2'b00, 2'b01, 4'd2, 4'd0, 2'b00, 5'd0,  8'h00, 2'b11, 8'h10, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 5'd2,  8'h00, 2'b11, 8'h32, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(2'b11, 2'b00, 4'd0, 4'd0, 2'b00, 5'd4,  8'h10, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(2'b01, 2'b00, 4'd0, 4'd0, 2'b00, 5'd2,  8'h02, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(2'b11, 2'b11, 4'd4, 4'd5, 2'b00, 5'd1,  8'h43, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(2'b01, 2'b00, 4'd0, 4'd0, 2'b00, 5'd1,  8'h03, 2'b11, 8'h54, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 2'b11, 4'd6, 4'd7, 2'b00, 5'd2,  8'h00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(2'b11, 2'b00, 4'd0, 4'd0, 2'b00, 5'd2,  8'h54, 2'b11, 8'h76, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 5'd2,  8'h00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
        run_table("A");

        // Asynchronous reset with 14 live entries.
        @(negedge clock);
        idle();
        reset = 1'b0;
        @(negedge clock);
        #1;
        chk("midreset empty",    64'(empty),    64'd1);
        chk("midreset dp_free",  64'(dp_free),  64'd16);
        chk("midreset rt_valid", 64'(rt_valid), 64'd0);
        chk("midreset flush",    64'(flush),    64'd0);
        chk("midreset full",     64'(full),     64'd0);
        reset = 1'b1;

        // Mispredict on lane 1, then on lane 0; CDB to an invalid entry is ignored.
        tbl.delete();
        tbl.push_back(mk(2'b11, 2'b00, 4'd0, 4'd0, 2'b00, 5'd16, 8'h10, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(2'b11, 2'b00, 4'd0, 4'd0, 2'b00, 5'd14, 8'h32, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 2'b11, 4'd0, 4'd1, 2'b10, 5'd12, 8'h00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(2'b11, 2'b11, 4'd2, 4'd3, 2'b00, 5'd12, 8'h54, 2'b11, 8'h10, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 2'b01, 4'd0, 4'd0, 2'b00, 5'd16, 8'h00, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(2'b11, 2'b00, 4'd0, 4'd0, 2'b00, 5'd16, 8'h10, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(2'b00, 2'b11, 4'd0, 4'd1, 2'b01, 5'd14, 8'h00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 5'd14, 8'h00, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 5'd16, 8'h00, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0));
        run_table("B");

        // Operand lookup of a tag completing on the CDB in the same cycle.
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            idle();
            dp_valid    = 2'b11;
            dp_has_dest = 2'b11;
        end
        @(negedge clock);
        idle();
        cdb_valid = 2'b01;
        cdb_tag   = {4'd0, 4'd5};
        cdb_value = {32'h0, 32'hC0DE0005};
        rd_tag    = {4'd0, 4'd0, 4'd4, 4'd5};
        #1;
`ifdef ROB_CDB_BYPASS_EN
        exp_byp = 1'b1;
`else
        exp_byp = 1'b0;
`endif
        chk("lookup same-cycle rd_ready0", 64'(rd_ready[0]),     64'(exp_byp));
        chk("lookup same-cycle rd_value0", 64'(rd_value[31:0]),  exp_byp ? 64'hC0DE0005 : 64'h0);
        chk("lookup same-cycle rd_ready1", 64'(rd_ready[1]),     64'd0);
        chk("lookup dp_free",              64'(dp_free),         64'd10);
        @(negedge clock);
        idle();
        rd_tag = {4'd0, 4'd0, 4'd4, 4'd5};
        #1;
        chk("lookup next-cycle rd_ready0", 64'(rd_ready[0]),     64'd1);
        chk("lookup next-cycle rd_value0", 64'(rd_value[31:0]),  64'hC0DE0005);
        chk("lookup next-cycle rd_ready1", 64'(rd_ready[1]),     64'd0);
        chk("lookup next-cycle rt_valid",  64'(rt_valid),        64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
